// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, fetch-encoding and IR-state definitions for the CPU core
package cpu_pkg;

  localparam int AW_DEF = 13;
  localparam int DW_DEF = 8;

  // 3-bit opcodes carried in ir_hi[7:5]
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDM = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STA = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_PRE = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  // Controller fetch command encodings
  localparam logic [1:0] FETCH_NONE = 2'b00;
  localparam logic [1:0] FETCH_HI   = 2'b01;
  localparam logic [1:0] FETCH_LO   = 2'b10;
  localparam logic [1:0] FETCH_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IR_EMPTY = 2'b00,
    IR_HALF  = 2'b01,
    IR_FULL  = 2'b10
  } ir_state_t;

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter register with load, increment and natural wrap
module pc_counter #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  output logic [AW-1:0] pc
);

  // Load beats increment; increment wraps modulo 2^AW through width truncation
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + {{(AW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, two-byte IR assembly and address mux
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    fetch,
  input  logic          ad_sel,
  input  logic          PC_en,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_load_val,
  input  logic [DW-1:0] rom_data,
  output logic [2:0]    ins,
  output logic [AW-1:0] ir_addr,
  output logic [AW-1:0] pc_addr,
  output logic [AW-1:0] addr,
  output logic [1:0]    ir_state,
  output logic          ir_err
);

  ir_state_t     state;
  logic [DW-1:0] ir_hi;
  logic [DW-1:0] ir_lo;

  // PC runs independently of the IR; a same-cycle byte load uses the old PC on addr
  pc_counter #(.AW(AW)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (PC_en),
    .pc       (pc_addr)
  );

  // IR assembly FSM; frozen during the data phase so the operand address stays stable
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IR_EMPTY;
      ir_hi  <= '0;
      ir_lo  <= '0;
      ir_err <= 1'b0;
    end else if (!ad_sel) begin
      case (fetch)
        FETCH_HI: begin
          // Any new opcode byte starts a fresh instruction, clearing a stale operand
          state <= IR_HALF;
          ir_hi <= rom_data;
          ir_lo <= '0;
        end
        FETCH_LO: begin
          case (state)
            IR_EMPTY: ir_err <= 1'b1;
            IR_HALF: begin
              state <= IR_FULL;
              ir_lo <= rom_data;
            end
            default: begin
              ir_lo  <= rom_data;
              ir_err <= 1'b1;
            end
          endcase
        end
        FETCH_ILL: ir_err <= 1'b1;
        default: ;
      endcase
    end
  end

  assign ins      = (state == IR_EMPTY) ? OP_NOP : ir_hi[DW-1:DW-3];
  assign ir_addr  = {ir_hi[AW-DW-1:0], ir_lo};
  assign ir_state = state;
  assign addr     = ad_sel ? ir_addr : pc_addr;

endmodule
